// File: rtl/mbank_sram.sv
// NBANK-bank scratch memory with rotating lane-to-bank mapping.
// Read data is routed back to the requesting lane, with an optional extra output stage.
module mbank_sram #(
  parameter int NBANK = 4,
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int RW    = $clog2(NBANK),
  parameter int OREG  = 0
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NBANK-1:0]       EN,
  input  logic [NBANK-1:0]       WE,
  input  logic [RW-1:0]          ROT,
  input  logic [NBANK*AW-1:0]    ADDR,
  input  logic [NBANK*WIDTH-1:0] D,
  output logic [NBANK*WIDTH-1:0] Q,
  output logic [NBANK-1:0]       QV
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [NBANK][DEPTH];

  logic [RW-1:0]    bank_lane [NBANK];
  logic [AW-1:0]    bank_addr [NBANK];
  logic [WIDTH-1:0] bank_wd   [NBANK];
  logic [WIDTH-1:0] bank_rd   [NBANK];
  logic [NBANK-1:0] bank_we;

  logic [RW-1:0]    lane_bank [NBANK];
  logic [WIDTH-1:0] lane_rd   [NBANK];
  logic [NBANK-1:0] rd_req;

  logic [NBANK*WIDTH-1:0] q1;
  logic [NBANK-1:0]       v1;

  // Bank b serves lane (b - ROT) mod NBANK; out-of-range addresses read as zero and never write.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bank_lane[b] = RW'(b) - ROT;
      bank_addr[b] = ADDR[bank_lane[b]*AW +: AW];
      bank_wd[b]   = D[bank_lane[b]*WIDTH +: WIDTH];
      bank_we[b]   = EN[bank_lane[b]] & WE[bank_lane[b]] & ({1'b0, bank_addr[b]} < DEPTH_W);
      bank_rd[b]   = '0;
      if ({1'b0, bank_addr[b]} < DEPTH_W) begin
        bank_rd[b] = mem[b][bank_addr[b]];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBANK; i++) begin
      lane_bank[i] = RW'(i) + ROT;
      lane_rd[i]   = bank_rd[lane_bank[i]];
      rd_req[i]    = EN[i] & ~WE[i];
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NBANK; b++) begin
      if (bank_we[b]) begin
        mem[b][bank_addr[b]] <= bank_wd[b];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q1 <= '0;
      v1 <= '0;
    end else begin
      v1 <= rd_req;
      for (int i = 0; i < NBANK; i++) begin
        if (rd_req[i]) begin
          q1[i*WIDTH +: WIDTH] <= lane_rd[i];
        end
      end
    end
  end

  // The extra stage only loads a lane when valid, so Q keeps holding between reads.
  generate
    if (OREG != 0) begin : g_oreg
      logic [NBANK*WIDTH-1:0] q2;
      logic [NBANK-1:0]       v2;

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          q2 <= '0;
          v2 <= '0;
        end else begin
          v2 <= v1;
          for (int i = 0; i < NBANK; i++) begin
            if (v1[i]) begin
              q2[i*WIDTH +: WIDTH] <= q1[i*WIDTH +: WIDTH];
            end
          end
        end
      end

      assign Q  = q2;
      assign QV = v2;
    end else begin : g_noreg
      assign Q  = q1;
      assign QV = v1;
    end
  endgenerate

endmodule

// File: tb/tb_mbank_sram.sv
// Bench for mbank_sram: a DEPTH=4/OREG=0 and a DEPTH=3/OREG=1 instance share stimulus
// and are checked every cycle against a lane/bank array model with explicit latency.
module tb_mbank_sram;

  logic         clk;
  logic         rstn;
  logic [3:0]   en;
  logic [3:0]   we;
  logic [1:0]   rot;
  logic [7:0]   addr;
  logic [255:0] d;
  logic [255:0] qA, qB;
  logic [3:0]   qvA, qvB;

  int vecCount;
  int errCount;

  logic [63:0]  memA [4][4];
  logic [63:0]  memB [4][3];
  logic [255:0] expQA, expQB, pendQB;
  logic [3:0]   expQVA, expQVB, pendQVB;

  mbank_sram #(.NBANK(4), .WIDTH(64), .DEPTH(4), .OREG(0)) dutA (
    .CLK(clk), .RSTN(rstn), .EN(en), .WE(we), .ROT(rot),
    .ADDR(addr), .D(d), .Q(qA), .QV(qvA)
  );

  mbank_sram #(.NBANK(4), .WIDTH(64), .DEPTH(3), .OREG(1)) dutB (
    .CLK(clk), .RSTN(rstn), .EN(en), .WE(we), .ROT(rot),
    .ADDR(addr), .D(d), .Q(qB), .QV(qvB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearModel();
    expQA   = '0;
    expQB   = '0;
    pendQB  = '0;
    expQVA  = '0;
    expQVB  = '0;
    pendQVB = '0;
  endtask

  // Lane i reaches bank (i + rot) mod 4; A answers one edge later, B two edges later.
  task automatic modelEdge();
    logic [3:0]   rdm;
    logic [255:0] resA, resB;
    int b, a;
    rdm  = en & ~we;
    resA = '0;
    resB = '0;
    for (int i = 0; i < 4; i++) begin
      b = (i + int'(rot)) % 4;
      a = int'(addr[i*2 +: 2]);
      if (rdm[i]) begin
        if (a < 4) resA[i*64 +: 64] = memA[b][a];
        if (a < 3) resB[i*64 +: 64] = memB[b][a];
      end
    end
    for (int i = 0; i < 4; i++) begin
      b = (i + int'(rot)) % 4;
      a = int'(addr[i*2 +: 2]);
      if (en[i] && we[i]) begin
        if (a < 4) memA[b][a] = d[i*64 +: 64];
        if (a < 3) memB[b][a] = d[i*64 +: 64];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pendQVB[i]) expQB[i*64 +: 64] = pendQB[i*64 +: 64];
      if (rdm[i])     expQA[i*64 +: 64] = resA[i*64 +: 64];
    end
    expQVB  = pendQVB;
    pendQVB = rdm;
    pendQB  = resB;
    expQVA  = rdm;
  endtask

  task automatic checkOutput(input string tag);
    vecCount++;
    assert (qvA === expQVA) else begin
      errCount++;
      $error("FAIL %s qvA: got %b want %b", tag, qvA, expQVA);
    end
    vecCount++;
    assert (qA === expQA) else begin
      errCount++;
      $error("FAIL %s qA: got %h want %h", tag, qA, expQA);
    end
    vecCount++;
    assert (qvB === expQVB) else begin
      errCount++;
      $error("FAIL %s qvB: got %b want %b", tag, qvB, expQVB);
    end
    vecCount++;
    assert (qB === expQB) else begin
      errCount++;
      $error("FAIL %s qB: got %h want %h", tag, qB, expQB);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] e, input logic [3:0] w, input logic [1:0] r,
                               input logic [7:0] a, input logic [255:0] dat, input string tag);
    en   = e;
    we   = w;
    rot  = r;
    addr = a;
    d    = dat;
    @(posedge clk);
    if (rstn) modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(4'h0, 4'h0, 2'd0, 8'h00, '0, tag);
  endtask

  task automatic readAll(input logic [1:0] r, input string tag);
    for (int a = 0; a < 4; a++) begin
      logic [1:0] a2;
      a2 = 2'(a);
      applyStimulus(4'hF, 4'h0, r, {a2, a2, a2, a2}, '0, tag);
    end
    idle(2, tag);
  endtask

  initial begin
    logic [255:0] fill;
    logic [1:0]   a2;
    vecCount = 0;
    errCount = 0;
    clearModel();
    en = '0; we = '0; rot = '0; addr = '0; d = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;

    idle(3, "reset");
    rstn = 1'b1;

    // Identity fill: lane i, address a holds 0x1000*i + a.
    for (int a = 0; a < 4; a++) begin
      a2 = 2'(a);
      for (int i = 0; i < 4; i++) fill[i*64 +: 64] = 64'(32'h1000 * i + a);
      applyStimulus(4'hF, 4'hF, 2'd0, {a2, a2, a2, a2}, fill, "fill");
    end
    readAll(2'd0, "identity");
    applyStimulus(4'hF, 4'h0, 2'd1, 8'hAA, '0, "rotate");
    idle(2, "rotate");

    applyStimulus(4'h4, 4'h0, 2'd0, 8'h10, '0, "single");
    idle(6, "hold");

    applyStimulus(4'h2, 4'h2, 2'd0, 8'h0C, {128'd0, 64'hDEAD, 64'd0}, "raw_wr");
    applyStimulus(4'h2, 4'h0, 2'd0, 8'h0C, '0, "raw_rd");
    applyStimulus(4'h2, 4'h0, 2'd0, 8'h00, '0, "b2b_rd");
    idle(3, "b2b");

    applyStimulus(4'hF, 4'hF, 2'd2, 8'hFF, {4{64'hFFFF}}, "oor_wr");
    readAll(2'd0, "oor_rd");

    for (int k = 0; k < 300; k++) begin
      applyStimulus(4'($urandom), 4'($urandom), 2'($urandom), 8'($urandom),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    "random");
    end
    idle(2, "drain");

    // Reads captured, then reset mid-cycle: outputs clear at once and in-flight data is dropped.
    applyStimulus(4'hF, 4'h0, 2'd3, 8'h55, '0, "pre_reset");
    en = '0;
    #2 rstn = 1'b0;
    clearModel();
    #1 checkOutput("async_reset");
    idle(2, "in_reset");
    rstn = 1'b1;
    idle(3, "post_reset");
    readAll(2'd0, "retained");
    readAll(2'd3, "retained_rot");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
